// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier slice.
package mult_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, ITER, FIXUP, DONE} state_t;

   localparam int unsigned DEF_WIDTH = 32;

   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/mult_seq_dp.sv
// Shift-add datapath: operand capture, magnitude conversion, iteration step and sign fix-up.
module mult_seq_dp
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               capture,
   input  logic               load,
   input  logic               step,
   input  logic               fix,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               eff_signed,
   output logic [2*WIDTH-1:0] product
);

   logic [WIDTH-1:0]   a_r, b_r, mcand, lo;
   logic [WIDTH:0]     hi;
   logic               sgn_r, neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] full, fixed;

   always_comb begin
      mag_a = (sgn_r && a_r[WIDTH-1]) ? -a_r : a_r;
      mag_b = (sgn_r && b_r[WIDTH-1]) ? -b_r : b_r;
      sum   = hi + (lo[0] ? {1'b0, mcand} : '0);
      full  = {hi[WIDTH-1:0], lo};
      fixed = neg ? -full : full;
   end

   // hi carries one extra bit so the add never overflows; the shift moves it back into range.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_r     <= '0;
         b_r     <= '0;
         sgn_r   <= 1'b0;
         mcand   <= '0;
         hi      <= '0;
         lo      <= '0;
         neg     <= 1'b0;
         product <= '0;
      end else if (capture) begin
         a_r   <= a;
         b_r   <= b;
         sgn_r <= eff_signed;
      end else if (load) begin
         mcand <= mag_a;
         lo    <= mag_b;
         hi    <= '0;
         neg   <= sgn_r && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
      end else if (step) begin
         hi <= {1'b0, sum[WIDTH:1]};
         lo <= {sum[0], lo[WIDTH-1:1]};
      end else if (fix) begin
         product <= fixed;
      end
   end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing FSM for the iterative multiplier: handshake, WIDTH-step iteration, abort and result hold.
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter bit          SIGNED_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            capture, load, step, fix;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (load)
            cnt <= '0;
         else if (step)
            cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      fix       = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               capture   = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               load      = 1'b1;
               state_nxt = ITER;
            end
         end
         ITER: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               step = 1'b1;
               if (cnt == CW'(WIDTH - 1))
                  state_nxt = FIXUP;
            end
         end
         FIXUP: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               fix       = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            // A pop and a discard both return to IDLE; product is left untouched either way.
            if (out_ready || abort)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   mult_seq_dp #(.WIDTH(WIDTH)) u_dp (
      .clk        (clk),
      .rst        (rst),
      .capture    (capture),
      .load       (load),
      .step       (step),
      .fix        (fix),
      .a          (a),
      .b          (b),
      .eff_signed (is_signed && SIGNED_EN),
      .product    (product)
   );

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench: one signed-enabled and one unsigned-only instance driven in lockstep.
`timescale 1ns/1ps
module tb_mult_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        is_signed = 1'b0;
   logic        abort = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready_s, out_valid_s, busy_s;
   logic        in_ready_u, out_valid_u, busy_u;
   logic [63:0] product_s, product_u;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] exp_s[$];
   logic [63:0] exp_u[$];

   always #5 clk = ~clk;

   mult_seq_ctrl #(.WIDTH(32), .SIGNED_EN(1'b1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .a(a), .b(b), .is_signed(is_signed), .abort(abort),
      .out_valid(out_valid_s), .out_ready(out_ready), .product(product_s), .busy(busy_s)
   );

   mult_seq_ctrl #(.WIDTH(32), .SIGNED_EN(1'b0)) dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
      .a(a), .b(b), .is_signed(is_signed), .abort(abort),
      .out_valid(out_valid_u), .out_ready(out_ready), .product(product_u), .busy(busy_u)
   );

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input logic sgn);
      longint sx, sy;
      sx = sgn ? longint'($signed(x)) : longint'({32'h0, x});
      sy = sgn ? longint'($signed(y)) : longint'({32'h0, y});
      return 64'(sx * sy);
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every product handed over must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && out_valid_s && out_ready) begin
         if (exp_s.size() == 0) check("pop_s_unexpected", 1, 0);
         else check("prod_s", product_s, exp_s.pop_front());
      end
      if (rst && out_valid_u && out_ready) begin
         if (exp_u.size() == 0) check("pop_u_unexpected", 1, 0);
         else check("prod_u", product_u, exp_u.pop_front());
      end
   end

   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic sgn);
      int i;
      for (i = 0; i < 200 && !in_ready_s; i++) begin
         @(posedge clk); #1;
      end
      if (!in_ready_s) check("issue_timeout", 0, 1);
      a = x; b = y; is_signed = sgn; in_valid = 1'b1;
      @(posedge clk);
      exp_s.push_back(ref_mul(x, y, sgn));
      exp_u.push_back(ref_mul(x, y, 1'b0));
      #1;
      in_valid  = 1'b0;
      a         = $urandom;
      b         = $urandom;
      is_signed = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid_s && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!out_valid_s) check("valid_timeout", 0, 1);
   endtask

   task automatic drain(input bit rnd);
      bit popped = 1'b0;
      for (int i = 0; i < 300 && !popped; i++) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         popped    = out_valid_s && out_ready;
         @(posedge clk); #1;
      end
      check("drain_done", 64'(popped), 1);
      out_ready = 1'b1;
   endtask

   initial begin
      int cyc;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready_s, 1);
      check("rst_out_valid", out_valid_s, 0);
      check("rst_busy", busy_s, 0);
      check("rst_product", product_s, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Basic latency and post-pop in_ready timing.
      issue(32'd3, 32'd5, 1'b0);
      wait_valid(cyc);
      check("latency_3x5", 64'(cyc), 34);
      @(posedge clk); #1;
      check("in_ready_after_pop", in_ready_s, 1);
      check("out_valid_after_pop", out_valid_s, 0);

      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      drain(0);
      issue(32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
      drain(0);
      issue(32'h8000_0000, 32'h8000_0000, 1'b1);
      drain(0);

      // Backpressure: result must hold while new operands are ignored.
      out_ready = 1'b0;
      issue(32'h0000_1234, 32'h0000_0010, 1'b0);
      wait_valid(cyc);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", out_valid_s, 1);
         check("bp_in_ready", in_ready_s, 0);
         check("bp_product", product_s, 64'h12340);
         in_valid = (i == 3);
         a = 32'd9; b = 32'd9;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_single_pop", out_valid_s, 0);
      check("bp_ready_back", in_ready_s, 1);
      issue(32'd6, 32'd7, 1'b0);
      drain(0);

      // Abort on the 10th iteration cycle.
      issue(32'h11, 32'h22, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      void'(exp_s.pop_back());
      void'(exp_u.pop_back());
      check("abort_busy", busy_s, 0);
      check("abort_in_ready", in_ready_s, 1);
      for (int i = 0; i < 40; i++) begin
         check("abort_no_valid", out_valid_s | out_valid_u, 0);
         @(posedge clk); #1;
      end
      check("abort_product_s", product_s, 64'h2A);
      check("abort_product_u", product_u, 64'h2A);
      issue(32'd6, 32'd7, 1'b0);
      wait_valid(cyc);
      check("latency_after_abort", 64'(cyc), 34);
      drain(0);

      // Asynchronous reset mid-iteration.
      issue(32'h0000_ABCD, 32'h0000_1234, 1'b0);
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b0;
      #2;
      check("arst_out_valid", out_valid_s, 0);
      check("arst_busy", busy_s, 0);
      check("arst_product", product_s, 0);
      check("arst_in_ready", in_ready_s, 1);
      exp_s.delete();
      exp_u.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      issue(32'd2, 32'd2, 1'b0);
      drain(0);

      // Randomized traffic with random consumer backpressure.
      for (int n = 0; n < 24; n++) begin
         issue(pick(), pick(), 1'($urandom_range(0, 1)));
         drain(1);
      end

      check("queue_s_empty", 64'(exp_s.size()), 0);
      check("queue_u_empty", 64'(exp_u.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
